// File: rtl/hazard_ctrl.sv
// LEGv8 five-stage pipeline sequencing controller.
// Resolves RAW stalls, branch flushes and data-memory wait/timeout.
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int WAIT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs2Valid_D,
  input  logic [4:0]       rd_E,
  input  logic             regWrite_E,
  input  logic [4:0]       rd_M,
  input  logic             regWrite_M,
  input  logic             PCSrc_M,
  input  logic             dmReq_M,
  input  logic             dmReady_M,
  output logic             pcEnable,
  output logic             ifidEnable,
  output logic             idexEnable,
  output logic             exmemEnable,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             memwbFlush,
  output logic             busErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushEvents
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_e;

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               busErr_q, busErr_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic               err_c, ms_c, br_c, raw_c;
  logic               haz_e, haz_m;
  logic [WAIT_W-1:0]  wait_inc;
  logic [7:0]         ctl;

  // X31 is XZR: writes to it are discarded, so it never carries a dependence
  assign haz_e = regWrite_E && (rd_E != 5'd31) &&
                 ((rs1_D == rd_E) ||
                  (rs2Valid_D && (rs2_D == rd_E)));
  assign haz_m = regWrite_M && (rd_M != 5'd31) &&
                 ((rs1_D == rd_M) ||
                  (rs2Valid_D && (rs2_D == rd_M)));

  assign err_c = (state_q == ERROR);
  assign ms_c  = !err_c && !dmReady_M &&
                 ((state_q == MEM_WAIT) ||
                  ((state_q == RUN) && dmReq_M));
  assign br_c  = !err_c && !ms_c && PCSrc_M;
  assign raw_c = !err_c && !ms_c && !PCSrc_M &&
                 (haz_e || haz_m);

  assign wait_inc = wait_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    // ctl = {pc,ifid,idex,exmem en, ifid,idex,exmem,memwb flush}
    ctl      = 8'b0000_0000;
    unique case (1'b1)
      err_c: begin
        ctl = 8'b0000_0000;
      end
      ms_c: begin
        ctl    = 8'b0000_0001;
        wait_d = wait_inc;
        if ((state_q == MEM_WAIT) && (wait_inc == TMO))
          state_d = ERROR;
        else
          state_d = MEM_WAIT;
      end
      br_c: begin
        ctl     = 8'b1111_1110;
        state_d = RUN;
        wait_d  = '0;
      end
      raw_c: begin
        ctl     = 8'b0011_0100;
        state_d = RUN;
        wait_d  = '0;
      end
      default: begin
        ctl     = 8'b1111_0000;
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    busErr_d = busErr_q || (state_d == ERROR);

    stall_d = stall_q;
    if (!err_c && !ctl[7] && (stall_q != CMAX))
      stall_d = stall_q + 1'b1;

    flush_d = flush_q;
    if (br_c && (flush_q != CMAX))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      wait_q   <= '0;
      busErr_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      busErr_q <= busErr_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  // reset forces every control line low without waiting for a clock
  assign {pcEnable, ifidEnable, idexEnable, exmemEnable,
          ifidFlush, idexFlush, exmemFlush, memwbFlush} =
         reset ? ctl : 8'b0000_0000;

  assign busErr      = busErr_q;
  assign stallCycles = stall_q;
  assign flushEvents = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam logic [7:0] RUNV = 8'b1111_0000;
  localparam logic [7:0] RAW  = 8'b0011_0100;
  localparam logic [7:0] MST  = 8'b0000_0001;
  localparam logic [7:0] BRF  = 8'b1111_1110;
  localparam logic [7:0] ZERO = 8'b0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  rs1_D, rs2_D, rd_E, rd_M;
  logic        rs2Valid_D, regWrite_E, regWrite_M;
  logic        PCSrc_M, dmReq_M, dmReady_M;
  logic        pcEnable, ifidEnable, idexEnable, exmemEnable;
  logic        ifidFlush, idexFlush, exmemFlush, memwbFlush;
  logic        busErr;
  logic [31:0] stallCycles, flushEvents;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs2Valid_D(rs2Valid_D),
    .rd_E(rd_E), .regWrite_E(regWrite_E),
    .rd_M(rd_M), .regWrite_M(regWrite_M),
    .PCSrc_M(PCSrc_M), .dmReq_M(dmReq_M), .dmReady_M(dmReady_M),
    .pcEnable(pcEnable), .ifidEnable(ifidEnable),
    .idexEnable(idexEnable), .exmemEnable(exmemEnable),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush),
    .exmemFlush(exmemFlush), .memwbFlush(memwbFlush),
    .busErr(busErr), .stallCycles(stallCycles),
    .flushEvents(flushEvents)
  );

  typedef struct {
    string      nm;
    logic [7:0] ctl;
    logic       bus;
    int         st;
    int         fl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int es = 0;
  int ef = 0;

  function automatic void chk(string nm, string f,
                              logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s %s got %0h want %0h", nm, f, a, e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "ctl",
          32'({pcEnable, ifidEnable, idexEnable, exmemEnable,
               ifidFlush, idexFlush, exmemFlush, memwbFlush}),
          32'(e.ctl));
      chk(e.nm, "busErr", 32'(busErr), 32'(e.bus));
      chk(e.nm, "stallCycles", stallCycles, e.st);
      chk(e.nm, "flushEvents", flushEvents, e.fl);
    end
  end

  task automatic vec(input string nm, input logic rst,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic r2v,
                     input logic [4:0] re, input logic we,
                     input logic [4:0] rm, input logic wm,
                     input logic br, input logic req,
                     input logic rdy,
                     input logic [7:0] ec, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    rs1_D      = r1;
    rs2_D      = r2;
    rs2Valid_D = r2v;
    rd_E       = re;
    regWrite_E = we;
    rd_M       = rm;
    regWrite_M = wm;
    PCSrc_M    = br;
    dmReq_M    = req;
    dmReady_M  = rdy;
    if (!rst) begin
      es = 0;
      ef = 0;
    end
    e.nm  = nm;
    e.ctl = ec;
    e.bus = eb;
    e.st  = es;
    e.fl  = ef;
    q.push_back(e);
    if (rst && !eb && !ec[7]) es++;
    if (rst && ec == BRF) ef++;
  endtask

  task automatic mem(input string nm, input logic br,
                     input logic req, input logic rdy,
                     input logic [7:0] ec, input logic eb);
    vec(nm, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
        br, req, rdy, ec, eb);
  endtask

  initial begin
    reset = 1'b0;
    rs1_D = '0; rs2_D = '0; rs2Valid_D = 1'b0;
    rd_E = '0; regWrite_E = 1'b0;
    rd_M = '0; regWrite_M = 1'b0;
    PCSrc_M = 1'b0; dmReq_M = 1'b0; dmReady_M = 1'b0;

    vec("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO, 0);
    vec("rst1", 0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, ZERO, 0);
    mem("idle", 0, 0, 0, RUNV, 0);

    vec("rawE", 1, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, RAW, 0);
    vec("rawM", 1, 1, 3, 1, 0, 0, 1, 1, 0, 0, 0, RAW, 0);
    vec("rawgo", 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, RUNV, 0);

    vec("xzr", 1, 31, 0, 0, 31, 1, 0, 0, 0, 0, 0, RUNV, 0);
    vec("rs2nv", 1, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, RUNV, 0);
    vec("rs2v", 1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, RAW, 0);
    vec("noWe", 1, 7, 0, 0, 7, 0, 7, 0, 0, 0, 0, RUNV, 0);

    mem("rdyIgn", 0, 0, 0, RUNV, 0);
    mem("wait1", 0, 1, 0, MST, 0);
    mem("wait2", 0, 1, 0, MST, 0);
    mem("wait3", 0, 1, 0, MST, 0);
    mem("memgo", 0, 1, 1, RUNV, 0);
    mem("zeroWait", 0, 1, 1, RUNV, 0);

    vec("brRaw", 1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0, BRF, 0);
    mem("postBr", 0, 0, 0, RUNV, 0);

    mem("brHeld", 1, 1, 0, MST, 0);
    mem("brApply", 1, 1, 1, BRF, 0);

    for (int i = 0; i < 5; i++) mem("preRst", 0, 1, 0, MST, 0);
    vec("rstWait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, 0);

    for (int i = 0; i < 16; i++) mem("tmo", 0, 1, 0, MST, 0);
    mem("err0", 0, 1, 0, ZERO, 1);
    mem("err1", 1, 1, 1, ZERO, 1);
    vec("err2", 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, ZERO, 1);

    vec("rstErr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, 0);
    mem("after", 0, 0, 0, RUNV, 0);
    mem("afterRaw", 0, 1, 1, RUNV, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage LEGv8 datapath (IF/ID/EX/MEM/WB, no forwarding network). Each cycle it decides which pipeline registers advance, hold or are flushed. It covers RAW data hazards, branch redirects resolved in MEM, and a ready/valid wait handshake with a variable-latency data memory. It also keeps saturating stall/flush performance counters and latches a sticky bus-error when a memory access times out.

## Interface
- CNT_W, 32: width of performance counters
- MEM_TIMEOUT, 16: max consecutive memory-wait stall cycles before error (≥2)
- WAIT_W, 5: width of wait counter (must hold MEM_TIMEOUT)

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- rs1_D  in  5  first source register of instruction in ID (Rn)
- rs2_D  in  5  second source register in ID (Rm or Rt per reg2loc)
- rs2Valid_D  in  1  instruction in ID reads rs2_D
- rd_E, regWrite_E  in  5/1  destination and write enable of instruction in EX
- rd_M, regWrite_M  in  5/1  destination and write enable of instruction in MEM
- PCSrc_M  in  1  branch taken, resolved in MEM
- dmReq_M  in  1  MEM-stage instruction accesses data memory (memRead|memWrite)
- dmReady_M  in  1  data memory completes access this cycle
- pcEnable  out  1  PC register load enable
- ifidEnable, idexEnable, exmemEnable  out  1  pipeline register load enables
- ifidFlush, idexFlush, exmemFlush, memwbFlush  out  1  load a bubble (all-zero) into that register
- busErr  out  1  sticky memory-timeout error
- stallCycles  out  CNT_W  cycles with pcEnable=0 outside ERROR
- flushEvents  out  CNT_W  number of branch flushes applied

## Operation
- States: RUN, MEM_WAIT, ERROR. Register 31 (XZR) never creates a hazard.
- Priority when several conditions hold in one cycle: ERROR > memory stall > branch flush > RAW stall.
- Memory stall (RUN with dmReq_M=1, dmReady_M=0; or MEM_WAIT with dmReady_M=0):
  - pc/ifid/idex/exmem enables = 0.
  - memwbFlush = 1.
  - waitCnt increments.
- Memory advance (dmReady_M=1, or dmReq_M=0 in RUN): normal flow; MEM_WAIT → RUN, waitCnt cleared.
- Timeout: a stall cycle in MEM_WAIT where waitCnt reaches MEM_TIMEOUT moves the next state to ERROR. With the default of 16, sixteen stall cycles occur, then ERROR.
- Branch flush (PCSrc_M=1, no memory stall):
  - ifidFlush, idexFlush and exmemFlush = 1; all enables = 1.
  - flushEvents increments.
  - Any coincident RAW stall is suppressed.
- RAW stall (no flush, no memory stall): rs1_D, or rs2_D when rs2Valid_D=1, equals rd_E with regWrite_E=1 or rd_M with regWrite_M=1.
  - pcEnable = ifidEnable = 0, idexFlush = 1.
  - EX/MEM onward advance.
- WB-stage producers are not checked: the register file returns the value written the same cycle.
- ERROR:
  - All enables 0, all flushes 0, busErr=1.
  - Counters frozen.
  - Exits only on reset.
- Counters saturate at 2^CNT_W−1. stallCycles counts any cycle in RUN/MEM_WAIT with pcEnable=0.

## Timing
- Control outputs are combinational from registered state and current inputs, acting at the same clock edge.
- State, waitCnt, busErr and counters update on posedge clk.
- Zero-wait memory access (dmReady_M=1 on the first request cycle) costs 0 stall cycles. Each low-ready cycle costs one.
- RAW dependence on EX: 2 stall cycles. Dependence on MEM only: 1 stall cycle.
- Branch penalty: 3 bubbles.
- Reset asserted (reset=0), asynchronously:
  - state=RUN, waitCnt=0, busErr=0, counters=0.
  - All enables 0, all flushes 0.
- After reset deassertion, outputs follow normal rules on the first cycle.
- Reset mid-MEM_WAIT or in ERROR returns to RUN and drops all stalls immediately.
- dmReady_M is ignored when dmReq_M=0.
- PCSrc_M coincident with a memory stall is held by the stall. It is applied in the cycle dmReady_M=1.

## Test plan
- Back-to-back ADD X1,… then ADD X2,X1,X3 (rd_E=1, regWrite_E=1, rs1_D=1) → pcEnable=0 and idexFlush=1 for 2 cycles, stallCycles=2.
- LDUR with dmReady_M low for 3 cycles → exmemEnable=0 and memwbFlush=1 for 3 cycles. Back to RUN on cycle 4; stallCycles=3, busErr=0.
- dmReady_M held low after a request → ERROR after 16 stall cycles. busErr=1, all enables 0, counters frozen; reset=0 clears everything.
- PCSrc_M=1 while ID holds a RAW hazard against rd_M → three flushes, enables 1, no stall, flushEvents=1.
- Hazards on register 31 (rd_E=31, rs1_D=31, regWrite_E=1) → no stall. rs2_D match with rs2Valid_D=0 → no stall.
- Assert reset during MEM_WAIT (waitCnt=5) → outputs immediately 0 and state RUN. Next request times out only after a full 16 cycles.
